// File: rtl/zlaswp_mem_pkg.sv
// Shared constants and types for the zlaswp AVMM memory responder.
package zlaswp_mem_pkg;

  localparam int AVMM_ADDR_W = 64;
  localparam int AVMM_DATA_W = 64;
  localparam int AVMM_BE_W   = 8;
  localparam int WORD_SHIFT  = 3;

  localparam int ERR_OOB   = 0;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_RW    = 2;

  typedef struct packed {
    logic                   valid;
    logic [AVMM_DATA_W-1:0] data;
  } rd_stage_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/zlaswp_mem_rdpipe.sv
// Valid/data delay line for returned read words; flush drops everything in flight.
module zlaswp_mem_rdpipe
  import zlaswp_mem_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic      clock,
  input  logic      flush,
  input  rd_stage_t stage_in,
  output rd_stage_t stage_out
);

  generate
    if (STAGES == 0) begin : g_pass
      assign stage_out = stage_in;
    end else begin : g_pipe
      rd_stage_t pipe [STAGES];

      always_ff @(posedge clock) begin
        if (flush) begin
          for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= stage_in;
          for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign stage_out = pipe[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/zlaswp_mem_responder.sv
// Fixed-latency AVMM word RAM responder with backdoor port, sticky errors and
// access counters; never stalls the master.
module zlaswp_mem_responder
  import zlaswp_mem_pkg::*;
#(
  parameter int                ADDR_W       = AVMM_ADDR_W,
  parameter int                DATA_W       = AVMM_DATA_W,
  parameter int                DEPTH_WORDS  = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                READ_LATENCY = 2,
  localparam int               BE_W         = DATA_W / 8,
  localparam int               IDX_W        = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avmm_address,
  input  logic [BE_W-1:0]   avmm_byteenable,
  input  logic              avmm_read,
  output logic [DATA_W-1:0] avmm_readdata,
  input  logic              avmm_write,
  input  logic [DATA_W-1:0] avmm_writedata,
  output logic              rd_valid,
  input  logic              bd_we,
  input  logic [IDX_W-1:0]  bd_addr,
  input  logic [DATA_W-1:0] bd_wdata,
  output logic [DATA_W-1:0] bd_rdata,
  input  logic              err_clear,
  output logic [2:0]        err_flags,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam logic [ADDR_W-1:0] SPAN_BYTES = ADDR_W'(DEPTH_WORDS) << WORD_SHIFT;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              misaligned;
  logic              wr_ok;
  logic              rd_take;
  logic              bd_ok;
  logic [2:0]        err_new;
  rd_stage_t         stage_in;
  rd_stage_t         pipe_out;

  // Unsigned subtract: addresses below BASE_ADDR wrap high and fall out of range.
  assign off        = avmm_address - BASE_ADDR;
  assign in_range   = off < SPAN_BYTES;
  assign misaligned = off[WORD_SHIFT-1:0] != '0;
  assign idx        = off[IDX_W+WORD_SHIFT-1:WORD_SHIFT];

  assign wr_ok   = avmm_write && in_range;
  assign rd_take = avmm_read && !avmm_write;
  // Collision on one word: suppress the backdoor so the AVMM byte lanes decide.
  assign bd_ok   = bd_we && !(wr_ok && (bd_addr == idx));

  always_ff @(posedge clock) begin
    if (bd_ok) mem[bd_addr] <= bd_wdata;
    if (wr_ok) begin
      for (int b = 0; b < BE_W; b++) begin
        if (avmm_byteenable[b]) mem[idx][b*8 +: 8] <= avmm_writedata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) bd_rdata <= '0;
    else       bd_rdata <= mem[bd_addr];
  end

  always_comb begin
    stage_in       = '0;
    stage_in.valid = rd_take && !reset;
    stage_in.data  = in_range ? AVMM_DATA_W'(mem[idx]) : '0;
  end

  // The output register is the last latency stage, so the pipe holds one fewer.
  zlaswp_mem_rdpipe #(
    .STAGES(READ_LATENCY - 1)
  ) u_rdpipe (
    .clock    (clock),
    .flush    (reset),
    .stage_in (stage_in),
    .stage_out(pipe_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      avmm_readdata <= '0;
      rd_valid      <= 1'b0;
    end else begin
      rd_valid <= pipe_out.valid;
      if (pipe_out.valid) avmm_readdata <= DATA_W'(pipe_out.data);
    end
  end

  always_comb begin
    err_new            = '0;
    err_new[ERR_OOB]   = (avmm_read || avmm_write) && !in_range;
    err_new[ERR_ALIGN] = (avmm_read || avmm_write) && misaligned;
    err_new[ERR_RW]    = avmm_read && avmm_write;
  end

  // Every request is accepted (no waitrequest), so out-of-range writes still count.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_flags <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      err_flags <= (err_clear ? 3'b000 : err_flags) | err_new;
      if (rd_take)    rd_count <= sat_inc(rd_count);
      if (avmm_write) wr_count <= sat_inc(wr_count);
    end
  end

endmodule
